// File: rtl/uart_alu_if.sv
// uart_alu_if: assembles a 3-byte command frame (A, B, opcode) from uart_rx,
// drives an external combinational ALU, and hands the result to uart_tx.
// Partial frames that go idle are dropped after TIMEOUT_CYCLES so the next
// byte starts a new frame. Bytes that arrive while a result is in flight are
// dropped and flagged as overrun.
module uart_alu_if #(
    parameter int N              = 8,
    parameter int OP_W           = 6,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    rx_data,
    input  logic            rx_valid,
    output logic [N-1:0]    alu_a,
    output logic [N-1:0]    alu_b,
    output logic [OP_W-1:0] alu_op,
    input  logic [N-1:0]    alu_result,
    output logic [N-1:0]    tx_data,
    output logic            tx_start,
    input  logic            tx_busy,
    input  logic            tx_done,
    output logic            frame_done,
    output logic            timeout_err,
    output logic            overrun_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        SEND,
        WAIT_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N-1:0]      a_q, a_d;
    logic [N-1:0]      b_q, b_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [N-1:0]      result_q, result_d;
    logic [N-1:0]      tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              frame_done_q, frame_done_d;
    logic              timeout_q, timeout_d;
    logic              overrun_q, overrun_d;

    // Next-state, operand capture, timeout counting and output pulse decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        result_d     = result_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        frame_done_d = 1'b0;
        timeout_d    = 1'b0;
        overrun_d    = 1'b0;

        case (state_q)
            WAIT_A: begin
                if (rx_valid) begin
                    a_d     = rx_data;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                // A byte arriving on the expiry cycle still wins.
                if (rx_valid) begin
                    b_d     = rx_data;
                    state_d = WAIT_OP;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = WAIT_A;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_OP: begin
                if (rx_valid) begin
                    op_d    = rx_data[OP_W-1:0];
                    state_d = EXEC;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = WAIT_A;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            EXEC: begin
                overrun_d = rx_valid;
                result_d  = alu_result;
                state_d   = SEND;
            end
            SEND: begin
                overrun_d = rx_valid;
                if (!tx_busy) begin
                    tx_data_d  = result_q;
                    tx_start_d = 1'b1;
                    state_d    = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // A byte coinciding with tx_done is still dropped; the frame completes.
                overrun_d = rx_valid;
                if (tx_done) begin
                    frame_done_d = 1'b1;
                    state_d      = WAIT_A;
                end
            end
            default: begin
                state_d = WAIT_A;
            end
        endcase
    end

    // State and datapath registers; asynchronous active-low reset clears everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= WAIT_A;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            result_q     <= '0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            frame_done_q <= 1'b0;
            timeout_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            result_q     <= result_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            frame_done_q <= frame_done_d;
            timeout_q    <= timeout_d;
            overrun_q    <= overrun_d;
        end
    end

    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_op      = op_q;
    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign frame_done  = frame_done_q;
    assign timeout_err = timeout_q;
    assign overrun_err = overrun_q;

endmodule

// File: tb/tb_uart_alu_if.sv
// Directed testbench for uart_alu_if: frame vectors from a table plus
// hand-written timeout, overrun, reset and back-to-back sequences.
module tb_uart_alu_if;

    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] alu_a, alu_b, alu_result, tx_data;
    logic [5:0] alu_op;
    logic       tx_start, tx_busy, tx_done;
    logic       frame_done, timeout_err, overrun_err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_start  = 0;
    int n_ovr    = 0;
    int n_to     = 0;
    int n_fd     = 0;
    int n_viol   = 0;
    logic p_start = 1'b0, p_fd = 1'b0, p_to = 1'b0, p_ov = 1'b0;

    uart_alu_if #(.N(8), .OP_W(6), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .frame_done  (frame_done),
        .timeout_err (timeout_err),
        .overrun_err (overrun_err)
    );

    always #5 clk = ~clk;

    // External ALU model: 0x20 add, 0x22 sub, anything else xor.
    always_comb begin
        case (alu_op)
            6'h20:   alu_result = alu_a + alu_b;
            6'h22:   alu_result = alu_a - alu_b;
            default: alu_result = alu_a ^ alu_b;
        endcase
    end

    // Pulse counting and one-cycle-width / exclusivity monitoring.
    always @(negedge clk) begin
        if (tx_start)    n_start++;
        if (overrun_err) n_ovr++;
        if (timeout_err) n_to++;
        if (frame_done)  n_fd++;
        if ((tx_start && p_start) || (frame_done && p_fd) || (timeout_err && p_to) ||
            (overrun_err && p_ov) || (timeout_err && overrun_err) || (tx_start && tx_busy))
            n_viol++;
        p_start = tx_start;
        p_fd    = frame_done;
        p_to    = timeout_err;
        p_ov    = overrun_err;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        repeat (gap) step();
    endtask

    // Sends the opcode byte and checks the T+3 tx_start latency (or release after busy).
    task automatic send_op(input logic [7:0] op, input logic [5:0] exp_op,
                           input logic [7:0] exp_res, input int busy, input string name);
        logic early;
        early   = 1'b0;
        tx_busy = (busy > 0);
        send_byte(op, 0);
        check({name, "_op"}, alu_op, exp_op);
        check({name, "_start_T1"}, tx_start, 0);
        step();
        if (tx_start) early = 1'b1;
        step();
        if (busy == 0) begin
            check({name, "_start_T3"}, tx_start, 1);
        end else begin
            if (tx_start) early = 1'b1;
            for (int i = 1; i < busy; i++) begin
                step();
                if (tx_start) early = 1'b1;
            end
            check({name, "_no_start_busy"}, early, 0);
            tx_busy = 1'b0;
            step();
            check({name, "_start_after_busy"}, tx_start, 1);
        end
        check({name, "_tx_data"}, tx_data, exp_res);
    endtask

    task automatic frame_to_start(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                                  input logic [5:0] exp_op, input logic [7:0] exp_res,
                                  input int busy, input string name);
        send_byte(a, 3);
        send_byte(b, 3);
        check({name, "_a"}, alu_a, a);
        check({name, "_b"}, alu_b, b);
        send_op(op, exp_op, exp_res, busy, name);
    endtask

    task automatic finish_frame(input logic [7:0] exp_res, input string name);
        repeat (3) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        check({name, "_frame_done"}, frame_done, 1);
        step();
        check({name, "_tx_data_hold"}, tx_data, exp_res);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [5:0] exp_op;
        logic [7:0] exp_res;
        int         busy;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int s0, o0, t0, k;

        vecs[0] = '{8'h05, 8'h03, 8'h20, 6'h20, 8'h08, 0};
        vecs[1] = '{8'h05, 8'h03, 8'h20, 6'h20, 8'h08, 10};
        vecs[2] = '{8'h0A, 8'h05, 8'h22, 6'h22, 8'h05, 0};
        vecs[3] = '{8'hFF, 8'h01, 8'h20, 6'h20, 8'h00, 0};
        vecs[4] = '{8'h12, 8'h34, 8'hE0, 6'h20, 8'h46, 0};
        vecs[5] = '{8'hF0, 8'h0F, 8'h3F, 6'h3F, 8'hFF, 3};
        vecs[6] = '{8'h03, 8'h05, 8'h22, 6'h22, 8'hFE, 0};

        reset    = 1'b0;
        rx_data  = '0;
        rx_valid = 1'b0;
        tx_busy  = 1'b0;
        tx_done  = 1'b0;
        repeat (3) step();
        check("reset_outputs",
              {alu_a, alu_b, alu_op, tx_data, tx_start, frame_done, timeout_err, overrun_err}, 0);
        reset = 1'b1;
        step();

        // Table-driven frames.
        for (int i = 0; i < 7; i++) begin
            frame_to_start(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp_op,
                           vecs[i].exp_res, vecs[i].busy, $sformatf("vec%0d", i));
            finish_frame(vecs[i].exp_res, $sformatf("vec%0d", i));
        end
        check("table_frame_done_count", n_fd, 7);

        // Timeout: only A arrives; expiry exactly TO cycles into WAIT_B.
        t0 = n_to;
        send_byte(8'h11, 0);
        k = 0;
        for (int i = 1; i <= 3 * TO; i++) begin
            step();
            if (timeout_err) begin
                k = i;
                break;
            end
        end
        check("timeout_latency", k, TO);
        check("timeout_alu_a_kept", alu_a, 8'h11);
        check("timeout_alu_b_kept", alu_b, 8'h05);
        frame_to_start(8'h02, 8'h02, 8'h20, 6'h20, 8'h04, 0, "realign");
        finish_frame(8'h04, "realign");
        check("timeout_count", n_to - t0, 1);

        // Byte on the expiry cycle is accepted instead of timing out.
        t0 = n_to;
        send_byte(8'h21, 0);
        repeat (TO - 1) step();
        send_byte(8'h07, 2);
        check("expiry_b_accepted", alu_b, 8'h07);
        send_op(8'h20, 6'h20, 8'h28, 0, "expiry");
        finish_frame(8'h28, "expiry");
        check("expiry_no_timeout", n_to - t0, 0);

        // Overrun in WAIT_DONE, then coincident with tx_done.
        o0 = n_ovr;
        frame_to_start(8'h05, 8'h03, 8'h20, 6'h20, 8'h08, 0, "ovr");
        step();
        send_byte(8'hFF, 0);
        check("ovr_pulse1", overrun_err, 1);
        check("ovr_a_kept1", alu_a, 8'h05);
        step();
        rx_data  = 8'hFF;
        rx_valid = 1'b1;
        tx_done  = 1'b1;
        step();
        rx_valid = 1'b0;
        tx_done  = 1'b0;
        check("ovr_pulse2", overrun_err, 1);
        check("ovr_a_kept2", alu_a, 8'h05);
        step();
        frame_to_start(8'h02, 8'h02, 8'h20, 6'h20, 8'h04, 0, "after_ovr");
        finish_frame(8'h04, "after_ovr");
        check("ovr_count", n_ovr - o0, 2);

        // Reset mid-frame, right after the B byte.
        send_byte(8'h33, 2);
        send_byte(8'h44, 0);
        reset = 1'b0;
        #1;
        check("midreset_outputs",
              {alu_a, alu_b, alu_op, tx_data, tx_start, frame_done, timeout_err, overrun_err}, 0);
        repeat (3) step();
        reset = 1'b1;
        s0 = n_start;
        repeat (20) step();
        check("midreset_no_start", n_start - s0, 0);
        frame_to_start(8'h0A, 8'h05, 8'h22, 6'h22, 8'h05, 0, "post_reset");
        finish_frame(8'h05, "post_reset");

        // Back-to-back frames at a slower byte rate.
        o0 = n_ovr;
        t0 = n_to;
        s0 = n_start;
        frame_to_start(8'h07, 8'h08, 8'h20, 6'h20, 8'h0F, 0, "b2b1");
        finish_frame(8'h0F, "b2b1");
        frame_to_start(8'h09, 8'h01, 8'h22, 6'h22, 8'h08, 0, "b2b2");
        finish_frame(8'h08, "b2b2");
        check("b2b_starts", n_start - s0, 2);
        check("b2b_no_errors", (n_ovr - o0) + (n_to - t0), 0);

        check("pulse_rules", n_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
